id_ex_stage: RTL

ID/EX pipeline register for the 5-stage RISC-V pipeline. It registers decoded operands and control from ID and presents them to EX. It also contains the load-use hazard detector and the forwarding-select generator that drives the EX operand muxes (forward_A/forward_B), so the EX operand-B mux receives RD_2, imm, ALUSrc and forward_B directly from this block.

---
 rtl/id_ex_stage.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register for the 5-stage RISC-V pipeline. It captures the
// decoded operands and control bits from ID and presents them to EX. It also
// contains two pieces of logic:
//   - the load-use hazard detector, which drives hz_stall to PC and IF/ID
//   - the forwarding-select generator for the EX operand muxes
//
// Parameters : XLEN (datapath width), REGW (register index width),
//              ALUCW (ALU control width)
// Inputs     : clk, rst_n (async, active low), id_* decoded instruction,
//              ex_flush (kill the ID instruction), ext_stall (freeze),
//              mem_rd/mem_regwrite (EX/MEM writer), wb_rd/wb_regwrite (MEM/WB)
// Outputs    : ex_* registered instruction, forward_a/forward_b
//              (00 register, 10 EX/MEM, 01 MEM/WB), hz_stall (combinational)
//
// Optional feature, enabled by defining ID_EX_STATS_EN:
//   stat_bubbles / stat_flushes, 16-bit saturating event counters.
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int REGW  = 5,
    parameter int ALUCW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rd1,
    input  logic [XLEN-1:0]  id_rd2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [REGW-1:0]  id_rs1,
    input  logic [REGW-1:0]  id_rs2,
    input  logic [REGW-1:0]  id_rd,
    input  logic             id_alusrc,
    input  logic [ALUCW-1:0] id_aluctrl,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_memtoreg,
    input  logic             id_branch,
    input  logic             ex_flush,
    input  logic             ext_stall,
    input  logic [REGW-1:0]  mem_rd,
    input  logic             mem_regwrite,
    input  logic [REGW-1:0]  wb_rd,
    input  logic             wb_regwrite,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rd1,
    output logic [XLEN-1:0]  ex_rd2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [REGW-1:0]  ex_rs1,
    output logic [REGW-1:0]  ex_rs2,
    output logic [REGW-1:0]  ex_rd,
    output logic             ex_alusrc,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_memtoreg,
    output logic             ex_branch,
    output logic [ALUCW-1:0] ex_aluctrl,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
`ifdef ID_EX_STATS_EN
    output logic [15:0]      stat_bubbles,
    output logic [15:0]      stat_flushes,
`endif
    output logic             hz_stall
);

    logic             r_valid;
    logic [XLEN-1:0]  r_pc, r_rd1, r_rd2, r_imm;
    logic [REGW-1:0]  r_rs1, r_rs2, r_rd;
    logic             r_alusrc, r_regwrite, r_memread, r_memwrite, r_memtoreg, r_branch;
    logic [ALUCW-1:0] r_aluctrl;

    logic             w_loadUse;
    logic             w_hzStall;
    logic             w_bubble;

    // A load in EX whose destination is read by the ID instruction. Both
    // sources are checked even when the instruction ignores rs2.
    assign w_loadUse = r_valid & r_memread & (r_rd != '0) &
                       ((r_rd == id_rs1) | (r_rd == id_rs2)) & id_valid;
    assign w_hzStall = w_loadUse & ~ex_flush;
    assign hz_stall  = w_hzStall;

    // Flush wins over everything, stall freezes, and a hazard inserts a bubble.
    assign w_bubble  = ex_flush | (~ext_stall & w_hzStall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_alusrc   <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_branch   <= 1'b0;
            r_aluctrl  <= '0;
        end else if (w_bubble) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_alusrc   <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_branch   <= 1'b0;
            r_aluctrl  <= '0;
        end else if (!ext_stall) begin
            // An empty ID slot still carries its data, but never any control.
            r_valid    <= id_valid;
            r_pc       <= id_pc;
            r_rd1      <= id_rd1;
            r_rd2      <= id_rd2;
            r_imm      <= id_imm;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_alusrc   <= id_alusrc   & id_valid;
            r_regwrite <= id_regwrite & id_valid;
            r_memread  <= id_memread  & id_valid;
            r_memwrite <= id_memwrite & id_valid;
            r_memtoreg <= id_memtoreg & id_valid;
            r_branch   <= id_branch   & id_valid;
            r_aluctrl  <= id_valid ? id_aluctrl : '0;
        end
    end

    assign ex_valid    = r_valid;
    assign ex_pc       = r_pc;
    assign ex_rd1      = r_rd1;
    assign ex_rd2      = r_rd2;
    assign ex_imm      = r_imm;
    assign ex_rs1      = r_rs1;
    assign ex_rs2      = r_rs2;
    assign ex_rd       = r_rd;
    assign ex_alusrc   = r_alusrc;
    assign ex_regwrite = r_regwrite;
    assign ex_memread  = r_memread;
    assign ex_memwrite = r_memwrite;
    assign ex_memtoreg = r_memtoreg;
    assign ex_branch   = r_branch;
    assign ex_aluctrl  = r_aluctrl;

    // EX/MEM is the younger result, so it wins a double match. x0 never
    // forwards, and a bubble in EX needs no forwarding at all.
    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (r_valid) begin
            if (mem_regwrite && (mem_rd != '0) && (mem_rd == r_rs1))
                forward_a = 2'b10;
            else if (wb_regwrite && (wb_rd != '0) && (wb_rd == r_rs1))
                forward_a = 2'b01;
            if (mem_regwrite && (mem_rd != '0) && (mem_rd == r_rs2))
                forward_b = 2'b10;
            else if (wb_regwrite && (wb_rd != '0) && (wb_rd == r_rs2))
                forward_b = 2'b01;
        end
    end

`ifdef ID_EX_STATS_EN
    logic [15:0] r_statBubbles;
    logic [15:0] r_statFlushes;

    // Only edges that actually load a bubble count; a frozen register does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_statBubbles <= '0;
            r_statFlushes <= '0;
        end else begin
            if (ex_flush && (r_statFlushes != 16'hFFFF))
                r_statFlushes <= r_statFlushes + 16'd1;
            if (!ex_flush && !ext_stall && w_hzStall && (r_statBubbles != 16'hFFFF))
                r_statBubbles <= r_statBubbles + 16'd1;
        end
    end

    assign stat_bubbles = r_statBubbles;
    assign stat_flushes = r_statFlushes;
`endif

endmodule
